// File: rtl/line_fetch_bcd.sv
// line_fetch_bcd: per-text-row fetch of binary values from a sync RAM,
// double-dabble conversion to BCD digit codes, packing into a back buffer
// and an atomic swap onto lineout. Row changes abort and restart a fill.
module line_fetch_bcd #(
   parameter int N            = 10,
   parameter int DIGITS       = 3,
   parameter int HCHAR        = 48,
   parameter int VCHAR        = 18,
   parameter int L            = 60,
   parameter int ADR_BITS     = 6,
   parameter int FONTVLENLOG2 = 5,
   parameter int LZB          = 0
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic [10:0]           vcnt,
   input  logic [2:0]            page,
   output logic [ADR_BITS-1:0]   rdadd,
   output logic                  rd_en,
   input  logic [N-1:0]          rdata,
   output logic [4*HCHAR-1:0]    lineout,
   output logic                  busy,
   output logic                  done
);

   localparam int VPL = HCHAR / DIGITS;
   localparam int W   = 4 * HCHAR;
   localparam int DW  = 4 * DIGITS;
   localparam int AW  = ADR_BITS + 8;
   localparam int KW  = $clog2(VPL + 1);
   localparam int CW  = $clog2(N + 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CONV, S_STORE, S_SWAP} state_t;

   state_t              state_q;
   logic [4:0]          row_q;
   logic                rowok_q;
   logic [AW-1:0]       base_q;
   logic [KW-1:0]       k_q;
   logic [ADR_BITS-1:0] rdadd_q;
   logic                rd_en_q;
   logic                inrng_q;
   logic [N-1:0]        sr_q;
   logic [DW-1:0]       bcd_q;
   logic                ovf_q;
   logic                blank_q;
   logic [CW-1:0]       cnt_q;
   logic [W-1:0]        back_q;
   logic [W-1:0]        lineout_q;
   logic                busy_q;
   logic                done_q;

   logic [4:0]          row;
   logic                row_ok;
   logic [AW-1:0]       a_start;
   logic [AW-1:0]       a_next;
   logic                unused_ok;

   assign row       = vcnt[FONTVLENLOG2 +: 5];
   assign row_ok    = int'(row) < VCHAR;
   assign a_start   = AW'(page) * AW'(VCHAR * VPL) + AW'(row) * AW'(VPL);
   assign a_next    = base_q + AW'(k_q) + AW'(1);
   assign unused_ok = ^vcnt;

   assign rdadd   = rdadd_q;
   assign rd_en   = rd_en_q;
   assign lineout = lineout_q;
   assign busy    = busy_q;
   assign done    = done_q;

   // one shift-add-3 step: adjust digits >=5, then shift in the next binary bit
   logic [DW-1:0] bcd_adj;
   logic [DW-1:0] bcd_sh;
   logic          carry;
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_sh = {bcd_adj[DW-2:0], sr_q[N-1]};
      carry  = bcd_adj[DW-1];
   end

   // digit codes for the value being stored: blank, overflow, or (blanked) BCD
   logic [DW-1:0] dig;
   logic          lead;
   int            lo_idx;
   always_comb begin
      dig  = bcd_q;
      lead = 1'b1;
      if (LZB != 0) begin
         // the units digit is never blanked so a zero value still shows "0"
         for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && dig[4*i +: 4] == 4'd0) dig[4*i +: 4] = 4'hF;
            else lead = 1'b0;
         end
      end
      if (ovf_q)   dig = {DIGITS{4'hE}};
      if (blank_q) dig = '1;
      lo_idx = W - DW * (int'(k_q) + 1);
   end

   // fill FSM; a row change in any state restarts the fill from k=0
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= S_IDLE;
         row_q     <= 5'h1F;
         rowok_q   <= 1'b0;
         base_q    <= '0;
         k_q       <= '0;
         rdadd_q   <= '0;
         rd_en_q   <= 1'b0;
         inrng_q   <= 1'b0;
         sr_q      <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         blank_q   <= 1'b0;
         cnt_q     <= '0;
         back_q    <= '1;
         lineout_q <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         if (row != row_q) begin
            // request for k=0 is set up here so rd_en is high during REQ
            row_q   <= row;
            rowok_q <= row_ok;
            base_q  <= a_start;
            k_q     <= '0;
            back_q  <= '1;
            busy_q  <= 1'b1;
            state_q <= S_REQ;
            inrng_q <= row_ok && (a_start < AW'(L));
            if (row_ok && (a_start < AW'(L))) begin
               rd_en_q <= 1'b1;
               rdadd_q <= a_start[ADR_BITS-1:0];
            end
         end else begin
            case (state_q)
               S_IDLE: ;
               S_REQ: begin
                  if (inrng_q) state_q <= S_WAIT;
                  else begin
                     blank_q <= 1'b1;
                     state_q <= S_STORE;
                  end
               end
               S_WAIT: begin
                  sr_q    <= rdata;
                  bcd_q   <= '0;
                  ovf_q   <= 1'b0;
                  blank_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_CONV;
               end
               S_CONV: begin
                  sr_q  <= {sr_q[N-2:0], 1'b0};
                  bcd_q <= bcd_sh;
                  if (carry) ovf_q <= 1'b1;
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(N - 1)) state_q <= S_STORE;
               end
               S_STORE: begin
                  back_q[lo_idx +: DW] <= dig;
                  k_q <= k_q + KW'(1);
                  if (k_q == KW'(VPL - 1)) state_q <= S_SWAP;
                  else begin
                     state_q <= S_REQ;
                     inrng_q <= rowok_q && (a_next < AW'(L));
                     if (rowok_q && (a_next < AW'(L))) begin
                        rd_en_q <= 1'b1;
                        rdadd_q <= a_next[ADR_BITS-1:0];
                     end
                  end
               end
               S_SWAP: begin
                  lineout_q <= back_q;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule
